// File: rtl/eth_hdr_extract_if.sv
// Byte-stream and header-strobe bundle between an rx front end and eth_hdr_extract.
// ivalid qualifies idata every cycle and there is no ready: the block accepts every byte, and all
// o* strobes are single-cycle pulses that downstream must take when they are high.
interface eth_hdr_extract_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 11
);
  logic [pDATA_WIDTH-1:0] idata;
  logic                   ivalid;
  logic [pDATA_WIDTH-1:0] odata;
  logic                   odst_valid;
  logic                   osrc_valid;
  logic [15:0]            oethertype;
  logic                   oethertype_valid;
  logic [pLEN_WIDTH-1:0]  olen;
  logic                   ofrm_done;
  logic                   oerr;
  logic [2:0]             dbg_state;

  modport master (
    output idata, ivalid,
    input  odata, odst_valid, osrc_valid, oethertype, oethertype_valid,
    input  olen, ofrm_done, oerr, dbg_state
  );

  modport slave (
    input  idata, ivalid,
    output odata, odst_valid, osrc_valid, oethertype, oethertype_valid,
    output olen, ofrm_done, oerr, dbg_state
  );
endinterface

// File: rtl/eth_hdr_extract.sv
// Ethernet rx header parser: strips preamble/SFD, strobes DA/SA bytes, captures EtherType,
// counts payload bytes (FCS included) and flags malformed frames. One cycle input-to-output.
module eth_hdr_extract #(
  parameter int               pDATA_WIDTH   = 8,
  parameter int               pMAC_BYTES    = 6,
  parameter int               pMAX_PREAMBLE = 7,
  parameter logic [7:0]       pSFD          = 8'hD5,
  parameter int               pLEN_WIDTH    = 11
) (
  input logic              iclk,
  input logic              irst_n,
  eth_hdr_extract_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DST  = 3'd2;
  localparam logic [2:0] S_SRC  = 3'd3;
  localparam logic [2:0] S_TYPE = 3'd4;
  localparam logic [2:0] S_PAY  = 3'd5;
  localparam logic [2:0] S_DROP = 3'd6;

  localparam int PRE_W  = $clog2(pMAX_PREAMBLE + 2);
  localparam int BYTE_W = (pMAC_BYTES > 2) ? $clog2(pMAC_BYTES) : 1;

  localparam logic [PRE_W-1:0]       PRE_MAX   = PRE_W'(pMAX_PREAMBLE);
  localparam logic [PRE_W-1:0]       PRE_ONE   = PRE_W'(1);
  localparam logic [BYTE_W-1:0]      BYTE_LAST = BYTE_W'(pMAC_BYTES - 1);
  localparam logic [BYTE_W-1:0]      BYTE_ONE  = BYTE_W'(1);
  localparam logic [pLEN_WIDTH-1:0]  LEN_MAX   = '1;
  localparam logic [pLEN_WIDTH-1:0]  LEN_ONE   = pLEN_WIDTH'(1);
  localparam logic [pDATA_WIDTH-1:0] PRE_BYTE  = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] SFD_BYTE  = pDATA_WIDTH'(pSFD);

  logic [2:0]             state;
  logic                   rvalid_d;
  logic [PRE_W-1:0]       pre_cnt;
  logic [PRE_W-1:0]       pre_base;
  logic [BYTE_W-1:0]      byte_cnt;
  logic [pDATA_WIDTH-1:0] type_hi;
  logic [pLEN_WIDTH-1:0]  pay_cnt;
  logic                   frame_start;

  logic [pDATA_WIDTH-1:0] odata_r;
  logic                   odst_valid_r;
  logic                   osrc_valid_r;
  logic [15:0]            oethertype_r;
  logic                   oethertype_valid_r;
  logic [pLEN_WIDTH-1:0]  olen_r;
  logic                   ofrm_done_r;
  logic                   oerr_r;

  // A rising ivalid is required to open a frame, so a frame already running at reset release is skipped.
  assign frame_start = (state == S_IDLE) && bus.ivalid && !rvalid_d;

  // The first byte of a frame is judged as preamble straight from IDLE with a zero count.
  always_comb begin
    pre_base = '0;
    if (state == S_PRE) pre_base = pre_cnt;
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state              <= S_IDLE;
      rvalid_d           <= 1'b1;
      pre_cnt            <= '0;
      byte_cnt           <= '0;
      type_hi            <= '0;
      pay_cnt            <= '0;
      odata_r            <= '0;
      odst_valid_r       <= 1'b0;
      osrc_valid_r       <= 1'b0;
      oethertype_r       <= '0;
      oethertype_valid_r <= 1'b0;
      olen_r             <= '0;
      ofrm_done_r        <= 1'b0;
      oerr_r             <= 1'b0;
    end else begin
      rvalid_d           <= bus.ivalid;
      odst_valid_r       <= 1'b0;
      osrc_valid_r       <= 1'b0;
      oethertype_valid_r <= 1'b0;
      ofrm_done_r        <= 1'b0;
      oerr_r             <= 1'b0;
      case (state)
        S_IDLE, S_PRE: begin
          if ((state == S_PRE) && !bus.ivalid) begin
            oerr_r <= 1'b1;
            state  <= S_IDLE;
          end else if (frame_start || (state == S_PRE)) begin
            if (bus.idata == PRE_BYTE) begin
              if (pre_base == PRE_MAX) begin
                oerr_r <= 1'b1;
                state  <= S_DROP;
              end else begin
                pre_cnt <= pre_base + PRE_ONE;
                state   <= S_PRE;
              end
            end else if (bus.idata == SFD_BYTE) begin
              byte_cnt <= '0;
              state    <= S_DST;
            end else begin
              oerr_r <= 1'b1;
              state  <= S_DROP;
            end
          end
        end
        S_DST, S_SRC: begin
          if (!bus.ivalid) begin
            oerr_r <= 1'b1;
            state  <= S_IDLE;
          end else begin
            odata_r      <= bus.idata;
            odst_valid_r <= (state == S_DST);
            osrc_valid_r <= (state == S_SRC);
            if (byte_cnt == BYTE_LAST) begin
              byte_cnt <= '0;
              state    <= (state == S_DST) ? S_SRC : S_TYPE;
            end else begin
              byte_cnt <= byte_cnt + BYTE_ONE;
            end
          end
        end
        S_TYPE: begin
          if (!bus.ivalid) begin
            oerr_r <= 1'b1;
            state  <= S_IDLE;
          end else if (byte_cnt == '0) begin
            type_hi  <= bus.idata;
            byte_cnt <= BYTE_ONE;
          end else begin
            oethertype_r       <= 16'({type_hi, bus.idata});
            oethertype_valid_r <= 1'b1;
            byte_cnt           <= '0;
            pay_cnt            <= '0;
            state              <= S_PAY;
          end
        end
        S_PAY: begin
          if (bus.ivalid) begin
            if (pay_cnt != LEN_MAX) pay_cnt <= pay_cnt + LEN_ONE;
          end else begin
            olen_r      <= pay_cnt;
            ofrm_done_r <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_DROP: begin
          if (!bus.ivalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.odata            = odata_r;
  assign bus.odst_valid       = odst_valid_r;
  assign bus.osrc_valid       = osrc_valid_r;
  assign bus.oethertype       = oethertype_r;
  assign bus.oethertype_valid = oethertype_valid_r;
  assign bus.olen             = olen_r;
  assign bus.ofrm_done        = ofrm_done_r;
  assign bus.oerr             = oerr_r;
  assign bus.dbg_state        = state;
endmodule

// File: tb/tb_eth_hdr_extract.sv
// Directed bench for eth_hdr_extract: good, malformed, runt, reset-mid-frame and saturating frames.
module tb_eth_hdr_extract;
  logic iclk = 1'b0;
  logic irst_n;
  always #5 iclk = ~iclk;

  eth_hdr_extract_if bus ();
  eth_hdr_extract dut (.iclk(iclk), .irst_n(irst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_cyc = 0;

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected DA/SA bytes in order, plus counters of every output event.
  logic [7:0]  exp_dst_q[$];
  logic [7:0]  exp_src_q[$];
  logic [10:0] len_q[$];
  int n_dst, n_src, n_type, n_done, n_err, n_excl, n_extra, err_cyc;
  logic [15:0] last_type;

  always @(negedge iclk) begin
    if ($countones({bus.odst_valid, bus.osrc_valid, bus.oethertype_valid,
                    bus.ofrm_done, bus.oerr}) > 1) n_excl++;
    if (bus.odst_valid) begin
      n_dst++;
      if (exp_dst_q.size() == 0) n_extra++;
      else check_eq("dst_byte", 32'(bus.odata), 32'(exp_dst_q.pop_front()));
    end
    if (bus.osrc_valid) begin
      n_src++;
      if (exp_src_q.size() == 0) n_extra++;
      else check_eq("src_byte", 32'(bus.odata), 32'(exp_src_q.pop_front()));
    end
    if (bus.oethertype_valid) begin
      n_type++;
      last_type = bus.oethertype;
    end
    if (bus.ofrm_done) begin
      n_done++;
      len_q.push_back(bus.olen);
    end
    if (bus.oerr) begin
      n_err++;
      err_cyc = cyc;
    end
  end

  task automatic reset_mon();
    exp_dst_q.delete();
    exp_src_q.delete();
    len_q.delete();
    n_dst = 0; n_src = 0; n_type = 0; n_done = 0; n_err = 0; n_excl = 0; n_extra = 0;
    err_cyc = -1;
    last_type = '0;
  endtask

  task automatic send(input logic v, input logic [7:0] d);
    bus.ivalid = v;
    bus.idata  = d;
    @(posedge iclk);
    #1;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 8'h00);
  endtask

  task automatic send_pre(input int n);
    repeat (n) send(1'b1, 8'h55);
    send(1'b1, 8'hD5);
  endtask

  task automatic send_frame(input logic [7:0] da_base, input logic [7:0] sa_base,
                            input logic [15:0] etype, input int pay_len);
    logic [7:0] b;
    send_pre(7);
    for (int i = 0; i < 6; i++) begin
      b = 8'(da_base + 8'(i));
      exp_dst_q.push_back(b);
      send(1'b1, b);
    end
    for (int i = 0; i < 6; i++) begin
      b = 8'(sa_base + 8'(i));
      exp_src_q.push_back(b);
      send(1'b1, b);
    end
    send(1'b1, etype[15:8]);
    send(1'b1, etype[7:0]);
    for (int i = 0; i < pay_len; i++) send(1'b1, 8'(i));
  endtask

  task automatic check_counts(input string tag, input int e_dst, input int e_src,
                              input int e_type, input int e_done, input int e_err);
    check_eq({tag, "_dst_cnt"}, 32'(n_dst), 32'(e_dst));
    check_eq({tag, "_src_cnt"}, 32'(n_src), 32'(e_src));
    check_eq({tag, "_type_cnt"}, 32'(n_type), 32'(e_type));
    check_eq({tag, "_done_cnt"}, 32'(n_done), 32'(e_done));
    check_eq({tag, "_err_cnt"}, 32'(n_err), 32'(e_err));
    check_eq({tag, "_dst_left"}, 32'(exp_dst_q.size()), 32'd0);
    check_eq({tag, "_src_left"}, 32'(exp_src_q.size()), 32'd0);
    check_eq({tag, "_extra"}, 32'(n_extra), 32'd0);
    check_eq({tag, "_excl"}, 32'(n_excl), 32'd0);
  endtask

  task automatic check_len(input string tag, input logic [10:0] e_len);
    if (len_q.size() > 0) check_eq(tag, 32'(len_q.pop_front()), 32'(e_len));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_odata"}, 32'(bus.odata), 32'd0);
    check_eq({tag, "_strobes"}, 32'({bus.odst_valid, bus.osrc_valid, bus.oethertype_valid,
                                     bus.ofrm_done, bus.oerr}), 32'd0);
    check_eq({tag, "_etype"}, 32'(bus.oethertype), 32'd0);
    check_eq({tag, "_olen"}, 32'(bus.olen), 32'd0);
    check_eq({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
  endtask

  int mark;

  initial begin
    irst_n     = 1'b0;
    bus.ivalid = 1'b0;
    bus.idata  = 8'h00;
    reset_mon();
    repeat (3) @(posedge iclk);
    #1;
    check_outputs_zero("reset");
    irst_n = 1'b1;
    idle(2);

    // 1: good frame, 46 payload + 4 FCS
    reset_mon();
    send_frame(8'h01, 8'h0A, 16'h0800, 50);
    idle(3);
    check_counts("t1", 6, 6, 1, 1, 0);
    check_eq("t1_etype", 32'(last_type), 32'h0800);
    check_len("t1_len", 11'd50);

    // 2: bad preamble byte, then a clean frame
    reset_mon();
    send(1'b1, 8'h55);
    send(1'b1, 8'h55);
    send(1'b1, 8'hAA);
    mark = last_cyc;
    send_pre(2);
    for (int i = 1; i <= 5; i++) send(1'b1, 8'(i));
    idle(2);
    check_counts("t2", 0, 0, 0, 0, 1);
    check_eq("t2_err_time", 32'(err_cyc), 32'(mark));
    reset_mon();
    send_frame(8'h11, 8'h21, 16'h86DD, 20);
    idle(2);
    check_counts("t2b", 6, 6, 1, 1, 0);
    check_eq("t2b_etype", 32'(last_type), 32'h86DD);
    check_len("t2b_len", 11'd20);

    // 3: runt ending after DA byte 3
    reset_mon();
    send_pre(7);
    for (int i = 1; i <= 3; i++) begin
      exp_dst_q.push_back(8'(i));
      send(1'b1, 8'(i));
    end
    idle(1);
    mark = last_cyc;
    idle(2);
    check_counts("t3", 3, 0, 0, 0, 1);
    check_eq("t3_err_time", 32'(err_cyc), 32'(mark));

    // 4: eight preamble bytes
    reset_mon();
    repeat (7) send(1'b1, 8'h55);
    send(1'b1, 8'h55);
    mark = last_cyc;
    send(1'b1, 8'hD5);
    for (int i = 1; i <= 6; i++) send(1'b1, 8'(i));
    idle(2);
    check_counts("t4", 0, 0, 0, 0, 1);
    check_eq("t4_err_time", 32'(err_cyc), 32'(mark));

    // 5: reset during SA with ivalid still high afterwards
    reset_mon();
    send_pre(7);
    for (int i = 1; i <= 6; i++) begin
      exp_dst_q.push_back(8'(i));
      send(1'b1, 8'(i));
    end
    exp_src_q.push_back(8'h0A);
    send(1'b1, 8'h0A);
    exp_src_q.push_back(8'h0B);
    send(1'b1, 8'h0B);
    irst_n = 1'b0;
    send(1'b1, 8'h0C);
    check_outputs_zero("t5_rst");
    send(1'b1, 8'h0D);
    irst_n = 1'b1;
    send(1'b1, 8'h0E);
    send(1'b1, 8'h0F);
    send_pre(3);
    for (int i = 1; i <= 14; i++) send(1'b1, 8'(i));
    idle(2);
    check_counts("t5", 6, 2, 0, 0, 0);
    reset_mon();
    send_frame(8'h51, 8'h61, 16'h8100, 8);
    idle(2);
    check_counts("t5b", 6, 6, 1, 1, 0);
    check_len("t5b_len", 11'd8);

    // 6: saturating payload, then a frame after a single idle cycle
    reset_mon();
    send_frame(8'h01, 8'h0A, 16'h0800, 2100);
    idle(1);
    send_frame(8'h31, 8'h41, 16'h0806, 64);
    idle(3);
    check_counts("t6", 12, 12, 2, 2, 0);
    check_eq("t6_etype", 32'(last_type), 32'h0806);
    check_len("t6_len_sat", 11'd2047);
    check_len("t6_len_b2b", 11'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
